// File: rtl/rocket_reset_pkg.sv
// Shared state encoding for the Rocket core reset sequencer.
// o_state exposes this encoding directly on the board LEDs.
package rocket_reset_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HOLD    = 2'b00,
    STRETCH = 2'b01,
    RUN     = 2'b10,
    DRAIN   = 2'b11
  } seqState_t;

endpackage

// File: rtl/reset_debounce.sv
// Synchronizes MMCM lock and the CPU-reset pushbutton into the core clock domain.
// RESET_SEQ_DEBOUNCE_EN selects the stable-count debounce; otherwise the synced button passes through.
module reset_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_mmcm_locked,
  input  logic i_cpu_reset,
  output logic o_locked_s,
  output logic o_button_deb
);

  logic [1:0] r_lockSync;
  logic [1:0] r_btnSync;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lockSync <= 2'b00;
      r_btnSync  <= 2'b00;
    end else begin
      r_lockSync <= {r_lockSync[0], i_mmcm_locked};
      r_btnSync  <= {r_btnSync[0], i_cpu_reset};
    end
  end

  assign o_locked_s = r_lockSync[1];

`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_stableCnt;
  logic             r_buttonDeb;

  // Counts consecutive cycles the synced level disagrees with the accepted level;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stableCnt <= '0;
      r_buttonDeb <= 1'b0;
    end else if (r_btnSync[1] == r_buttonDeb) begin
      r_stableCnt <= '0;
    end else if (r_stableCnt == CNT_LAST) begin
      r_stableCnt <= '0;
      r_buttonDeb <= r_btnSync[1];
    end else begin
      r_stableCnt <= r_stableCnt + 1'b1;
    end
  end

  assign o_button_deb = r_buttonDeb;
`else
  assign o_button_deb = r_btnSync[1];
`endif

endmodule

// File: rtl/rocket_reset_sequencer.sv
// Core reset sequencer for the Rocket Top: lock/button driven FSM with AXI drain before button resets.
// Build option RESET_SEQ_DEBOUNCE_EN enables the pushbutton debounce counter in reset_debounce.
module rocket_reset_sequencer
  import rocket_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int STRETCH_CYCLES  = 64,
  parameter int DRAIN_TIMEOUT   = 4096,
  parameter int OUTSTANDING_W   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_mmcm_locked,
  input  logic               i_cpu_reset,
  input  logic               i_axi_awvalid,
  input  logic               i_axi_awready,
  input  logic               i_axi_bvalid,
  input  logic               i_axi_bready,
  input  logic               i_axi_arvalid,
  input  logic               i_axi_arready,
  input  logic               i_axi_rvalid,
  input  logic               i_axi_rready,
  input  logic               i_axi_rlast,
  output logic               o_core_reset,
  output logic [STATE_W-1:0] o_state,
  output logic               o_drain_timeout
);

  localparam int STR_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam int TMO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [STR_W-1:0] STRETCH_LAST = STR_W'(STRETCH_CYCLES - 1);
  localparam logic [TMO_W-1:0] DRAIN_LAST   = TMO_W'(DRAIN_TIMEOUT - 1);

  logic w_lockedS;
  logic w_buttonDeb;
  logic w_awFire, w_bFire, w_arFire, w_rFire;
  logic w_timeoutHit;

  seqState_t r_state, w_stateNext;
  logic      r_coreReset;
  logic      r_drainTimeout;

  logic [STR_W-1:0]         r_stretchCnt;
  logic [TMO_W-1:0]         r_drainCnt;
  logic [OUTSTANDING_W-1:0] r_wrOut, r_rdOut, w_wrNext, w_rdNext;

  reset_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .rstn         (rstn),
    .i_mmcm_locked(i_mmcm_locked),
    .i_cpu_reset  (i_cpu_reset),
    .o_locked_s   (w_lockedS),
    .o_button_deb (w_buttonDeb)
  );

  assign w_awFire = i_axi_awvalid & i_axi_awready;
  assign w_bFire  = i_axi_bvalid & i_axi_bready;
  assign w_arFire = i_axi_arvalid & i_axi_arready;
  assign w_rFire  = i_axi_rvalid & i_axi_rready & i_axi_rlast;

  // Saturating outstanding counts; held at zero while the core is in reset.
  always_comb begin
    w_wrNext = r_wrOut;
    w_rdNext = r_rdOut;
    if (r_coreReset) begin
      w_wrNext = '0;
      w_rdNext = '0;
    end else begin
      if (w_awFire && !w_bFire && r_wrOut != '1)       w_wrNext = r_wrOut + 1'b1;
      else if (!w_awFire && w_bFire && r_wrOut != '0)  w_wrNext = r_wrOut - 1'b1;
      if (w_arFire && !w_rFire && r_rdOut != '1)       w_rdNext = r_rdOut + 1'b1;
      else if (!w_arFire && w_rFire && r_rdOut != '0)  w_rdNext = r_rdOut - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wrOut <= '0;
      r_rdOut <= '0;
    end else begin
      r_wrOut <= w_wrNext;
      r_rdOut <= w_rdNext;
    end
  end

  // RUN is only entered with the button released, so its level in RUN marks a new press.
  always_comb begin
    w_stateNext  = r_state;
    w_timeoutHit = 1'b0;
    case (r_state)
      HOLD: begin
        if (w_lockedS && !w_buttonDeb) w_stateNext = STRETCH;
      end
      STRETCH: begin
        if (!w_lockedS || w_buttonDeb)        w_stateNext = HOLD;
        else if (r_stretchCnt == STRETCH_LAST) w_stateNext = RUN;
      end
      RUN: begin
        if (!w_lockedS)       w_stateNext = HOLD;
        else if (w_buttonDeb) w_stateNext = DRAIN;
      end
      DRAIN: begin
        if (!w_lockedS) begin
          w_stateNext = HOLD;
        end else if (w_wrNext == '0 && w_rdNext == '0) begin
          w_stateNext = HOLD;
        end else if (r_drainCnt == DRAIN_LAST) begin
          w_stateNext  = HOLD;
          w_timeoutHit = 1'b1;
        end
      end
      default: w_stateNext = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= HOLD;
      r_coreReset    <= 1'b1;
      r_drainTimeout <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_coreReset <= (w_stateNext == HOLD) || (w_stateNext == STRETCH);
      if (w_timeoutHit) r_drainTimeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stretchCnt <= '0;
      r_drainCnt   <= '0;
    end else begin
      r_stretchCnt <= (r_state == STRETCH && w_stateNext == STRETCH) ? r_stretchCnt + 1'b1 : '0;
      r_drainCnt   <= (r_state == DRAIN && w_stateNext == DRAIN) ? r_drainCnt + 1'b1 : '0;
    end
  end

  assign o_core_reset    = r_coreReset;
  assign o_state         = r_state;
  assign o_drain_timeout = r_drainTimeout;

endmodule
